// File: rtl/idelay_tap_ctrl.sv
// Run-time tap controller for an IDELAYE2 in VAR_LOAD mode, gated by IDELAYCTRL RDY.
// Optional readback check of CNTVALUEOUT against the expected tap: define TAP_VERIFY_EN.
module idelay_tap_ctrl #(
    parameter int TAP_W      = 5,
    parameter int INIT_TAP   = 0,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clki,
    input  logic             rsti,
    input  logic             dly_rdy,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [TAP_W-1:0] req_val,
    output logic             dly_ld,
    output logic             dly_ce,
    output logic             dly_inc,
    output logic [TAP_W-1:0] dly_cntin,
    input  logic [TAP_W-1:0] dly_cntout,
    output logic [TAP_W-1:0] tap_cur,
    output logic             done,
    output logic             sat,
    output logic             err
);

    localparam logic [2:0] WAIT_RDY = 3'd0;
    localparam logic [2:0] INIT_LD  = 3'd1;
    localparam logic [2:0] IDLE     = 3'd2;
    localparam logic [2:0] PULSE    = 3'd3;
    localparam logic [2:0] SETTLE   = 3'd4;
    localparam logic [2:0] CHECK    = 3'd5;

    localparam logic [TAP_W-1:0] TAP_MAX   = '1;
    localparam logic [TAP_W-1:0] TAP_INIT  = TAP_W'(INIT_TAP);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;

    logic       rdy_m, rdy_s;
    logic [2:0] state, nxt;
    logic [7:0] cnt;
    logic       accept;

    always_ff @(posedge clki or negedge rsti) begin
        if (!rsti) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_m <= dly_rdy;
            rdy_s <= rdy_m;
        end
    end

    assign req_ready = (state == IDLE) && rdy_s;
    assign accept    = req_valid && req_ready;

    always_comb begin
        nxt = state;
        case (state)
            WAIT_RDY: if (rdy_s) nxt = INIT_LD;
            INIT_LD:  nxt = SETTLE;
            IDLE:     if (accept) nxt = PULSE;
            PULSE:    nxt = SETTLE;
            SETTLE:   if (cnt == SETTLE_LAST) nxt = CHECK;
            CHECK:    nxt = IDLE;
            default:  nxt = WAIT_RDY;
        endcase
        // Losing RDY anywhere past WAIT_RDY drops the operation; INIT_LD reloads on return.
        if (state != WAIT_RDY && !rdy_s) nxt = WAIT_RDY;
    end

    always_ff @(posedge clki or negedge rsti) begin
        if (!rsti) begin
            state     <= WAIT_RDY;
            cnt       <= '0;
            dly_ld    <= 1'b0;
            dly_ce    <= 1'b0;
            dly_inc   <= 1'b0;
            dly_cntin <= TAP_INIT;
            tap_cur   <= TAP_INIT;
            done      <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= (state == SETTLE) ? cnt + 8'd1 : 8'd0;
            dly_ld  <= 1'b0;
            dly_ce  <= 1'b0;
            dly_inc <= 1'b0;
            done    <= (nxt == CHECK);
            if (nxt == INIT_LD) begin
                dly_ld    <= 1'b1;
                dly_cntin <= TAP_INIT;
                tap_cur   <= TAP_INIT;
            end
            if (accept) begin
                case (req_op)
                    OP_LD: begin
                        dly_ld    <= 1'b1;
                        dly_cntin <= req_val;
                        tap_cur   <= req_val;
                        sat       <= 1'b0;
                    end
                    OP_INC: begin
                        if (tap_cur != TAP_MAX) begin
                            dly_ce  <= 1'b1;
                            dly_inc <= 1'b1;
                            tap_cur <= tap_cur + 1'b1;
                        end else begin
                            sat <= 1'b1;
                        end
                    end
                    OP_DEC: begin
                        if (tap_cur != '0) begin
                            dly_ce  <= 1'b1;
                            tap_cur <= tap_cur - 1'b1;
                        end else begin
                            sat <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
`ifdef TAP_VERIFY_EN
            // Readback is sampled on the last settle cycle so err/tap_cur line up with done.
            if (nxt == CHECK && dly_cntout != tap_cur) tap_cur <= dly_cntout;
`endif
        end
    end

`ifdef TAP_VERIFY_EN
    always_ff @(posedge clki or negedge rsti) begin
        if (!rsti)                                      err <= 1'b0;
        else if (nxt == INIT_LD)                        err <= 1'b0;
        else if (nxt == CHECK && dly_cntout != tap_cur) err <= 1'b1;
    end
`else
    logic unused_cntout;
    assign unused_cntout = ^dly_cntout;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// Randomized bench for idelay_tap_ctrl against a request-level tap/sat model and a simple IDELAY line model.
module tb_idelay_tap_ctrl;
    localparam int TAP_W    = 5;
    localparam int INIT_TAP = 0;
    localparam int SC       = 4;
    localparam int TMAX     = (1 << TAP_W) - 1;

    logic             clki = 1'b0;
    logic             rsti = 1'b0;
    logic             dly_rdy = 1'b0;
    logic             req_valid = 1'b0;
    logic [1:0]       req_op = 2'b00;
    logic [TAP_W-1:0] req_val = '0;
    logic             req_ready, dly_ld, dly_ce, dly_inc, done, sat, err;
    logic [TAP_W-1:0] dly_cntin, dly_cntout, tap_cur;

    idelay_tap_ctrl #(.TAP_W(TAP_W), .INIT_TAP(INIT_TAP), .SETTLE_CYC(SC)) dut (
        .clki(clki), .rsti(rsti), .dly_rdy(dly_rdy),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_val(req_val),
        .dly_ld(dly_ld), .dly_ce(dly_ce), .dly_inc(dly_inc), .dly_cntin(dly_cntin),
        .dly_cntout(dly_cntout), .tap_cur(tap_cur), .done(done), .sat(sat), .err(err)
    );

    always #5 clki = ~clki;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int line_tap = 0;
    bit corrupt = 1'b0;

    int exp_tap = INIT_TAP;
    int exp_cntin = INIT_TAP;
    bit exp_sat = 1'b0;
    bit exp_err = 1'b0;

    // Behavioural IDELAYE2 counter, readback optionally skewed by one tap.
    always @(posedge clki) begin
        cyc <= cyc + 1;
        if (dly_ld)      line_tap <= int'(dly_cntin);
        else if (dly_ce) line_tap <= dly_inc ? line_tap + 1 : line_tap - 1;
    end
    assign dly_cntout = corrupt ? TAP_W'(line_tap - 1) : TAP_W'(line_tap);

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clki);
    endtask

    task automatic settle_and_done(input string tag);
        for (int k = 0; k < SC; k++) begin
            tick();
            chk({tag, ".settle_done"}, done, 0);
            chk({tag, ".settle_pulse"}, dly_ld | dly_ce, 0);
        end
        tick();
`ifdef TAP_VERIFY_EN
        if (corrupt) begin
            exp_err = 1'b1;
            exp_tap = exp_tap - 1;
        end
`endif
        chk({tag, ".done"}, done, 1);
        chk({tag, ".done_tap"}, tap_cur, exp_tap);
        chk({tag, ".done_err"}, err, exp_err);
        chk({tag, ".done_sat"}, sat, exp_sat);
        tick();
        chk({tag, ".done_1cyc"}, done, 0);
        chk({tag, ".ready_after"}, req_ready, 1);
    endtask

    task automatic bringup(input string tag);
        int t;
        dly_rdy = 1'b1;
        t = 0;
        while (!dly_ld && t < 10) begin
            tick();
            t++;
        end
        chk({tag, ".ld_latency"}, t, 3);
        chk({tag, ".ld_cntin"}, dly_cntin, INIT_TAP);
        chk({tag, ".ld_tap"}, tap_cur, INIT_TAP);
        chk({tag, ".ld_ready"}, req_ready, 0);
        exp_tap = INIT_TAP;
        exp_cntin = INIT_TAP;
        exp_err = 1'b0;
        tick();
        chk({tag, ".ld_1cyc"}, dly_ld, 0);
        // dly_ld at cycle M, SETTLE M+1..M+SC-1 already one consumed above
        for (int k = 1; k < SC; k++) begin
            tick();
            chk({tag, ".init_settle_done"}, done, 0);
        end
        tick();
        chk({tag, ".init_done"}, done, 1);
        chk({tag, ".init_err"}, err, 0);
        tick();
        chk({tag, ".init_ready"}, req_ready, 1);
    endtask

    // Waits for ready, returns with the request accepted and the bench at cycle N+1.
    task automatic accept_req(input string tag, input logic [1:0] op, input int val, output bit ok);
        int t;
        req_valid = 1'b1;
        req_op = op;
        req_val = TAP_W'(val);
        t = 0;
        while (!req_ready && t < 50) begin
            tick();
            t++;
        end
        ok = req_ready;
        if (!ok) begin
            chk({tag, ".ready_timeout"}, 0, 1);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        req_op = 2'($urandom);
        req_val = TAP_W'($urandom);
    endtask

    task automatic send(input string tag, input logic [1:0] op, input int val);
        bit ok, e_ld, e_ce, e_inc;
        e_ld = 0; e_ce = 0; e_inc = 0;
        case (op)
            2'b00: begin e_ld = 1; exp_tap = val; exp_cntin = val; exp_sat = 0; end
            2'b01: if (exp_tap < TMAX) begin e_ce = 1; e_inc = 1; exp_tap++; end else exp_sat = 1;
            2'b10: if (exp_tap > 0) begin e_ce = 1; exp_tap--; end else exp_sat = 1;
            default: ;
        endcase
        accept_req(tag, op, val, ok);
        if (!ok) return;
        chk({tag, ".ld"}, dly_ld, e_ld);
        chk({tag, ".ce"}, dly_ce, e_ce);
        chk({tag, ".inc"}, dly_inc, e_inc);
        chk({tag, ".cntin"}, dly_cntin, exp_cntin);
        chk({tag, ".tap"}, tap_cur, exp_tap);
        chk({tag, ".sat"}, sat, exp_sat);
        settle_and_done(tag);
    endtask

    initial begin
        bit ok;
        int t, a0, a1, na;

        #1;
        chk("rst.ready", req_ready, 0);
        chk("rst.ld", dly_ld, 0);
        chk("rst.ce", dly_ce | dly_inc, 0);
        chk("rst.cntin", dly_cntin, INIT_TAP);
        chk("rst.tap", tap_cur, INIT_TAP);
        chk("rst.done", done | sat | err, 0);
        repeat (3) tick();
        rsti = 1'b1;
        while (cyc < 10) tick();
        chk("pre_rdy.ready", req_ready, 0);
        bringup("init");

        send("ld17", 2'b00, 17);
        send("ld31", 2'b00, 31);
        send("inc_max", 2'b01, 0);
        send("dec31", 2'b10, 0);
        send("ld5", 2'b00, 5);
        send("ld0", 2'b00, 0);
        send("dec0", 2'b10, 0);
        send("nop", 2'b11, 9);

        // back-to-back with valid held high
        req_valid = 1'b1;
        req_op = 2'b11;
        na = 0; a0 = 0; a1 = 0; t = 0;
        while (na < 2 && t < 40) begin
            if (req_ready) begin
                if (na == 0) a0 = cyc; else a1 = cyc;
                na++;
            end
            if (na < 2) begin tick(); t++; end
        end
        tick();
        req_valid = 1'b0;
        chk("b2b.accepts", na, 2);
        chk("b2b.spacing", a1 - a0, SC + 3);
        t = 0;
        while (!done && t < 20) begin tick(); t++; end
        chk("b2b.done_seen", done, 1);
        chk("b2b.tap", tap_cur, exp_tap);
        tick();

        for (int i = 0; i < 40; i++) begin
            int sel, v;
            logic [1:0] op;
            repeat ($urandom_range(0, 3)) tick();
            op = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            v = (sel == 0) ? 0 : (sel == 1) ? TMAX : $urandom_range(0, TMAX);
            send($sformatf("rnd%0d", i), op, v);
        end

        // loss of ready during settle of a load to 12
        accept_req("drop", 2'b00, 12, ok);
        if (ok) begin
            exp_sat = 1'b0;
            chk("drop.ld", dly_ld, 1);
            chk("drop.cntin", dly_cntin, 12);
            chk("drop.tap", tap_cur, 12);
            tick();
            dly_rdy = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                chk("drop.no_done", done, 0);
                chk("drop.ready", req_ready, 0);
            end
            bringup("reload");
            chk("reload.sat", sat, 0);
        end

        // readback mismatch: line reports one tap below what was loaded
        corrupt = 1'b1;
        send("verify10", 2'b00, 10);
        corrupt = 1'b0;
        dly_rdy = 1'b0;
        repeat (6) tick();
        bringup("clr");

        // asynchronous reset mid-operation
        send("ld21", 2'b00, 21);
        accept_req("rstmid", 2'b01, 0, ok);
        tick();
        rsti = 1'b0;
        #1;
        chk("rstmid.tap", tap_cur, INIT_TAP);
        chk("rstmid.cntin", dly_cntin, INIT_TAP);
        chk("rstmid.ready", req_ready, 0);
        chk("rstmid.flags", done | sat | err | dly_ld | dly_ce, 0);
        tick();
        rsti = 1'b1;
        exp_sat = 1'b0;
        bringup("post_rst");
        send("post_ld7", 2'b00, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
